// File: rtl/adc_seq_pkg.sv
// Shared types and helpers for the ADC board power-up / config / link-check sequencer.
package adc_seq_pkg;

  typedef enum logic [2:0] {
    ST_SCAN = 3'd0,
    ST_PWR  = 3'd1,
    ST_CFG  = 3'd2,
    ST_CHK  = 3'd3,
    ST_RUN  = 3'd4
  } seq_state_t;

  localparam logic [11:0] LEVEL_LO_DEF = 12'h7B7;
  localparam logic [11:0] LEVEL_HI_DEF = 12'h81B;

  // Inclusive window compare; callers zero-extend samples and bounds to 32 bits.
  function automatic logic in_window(input logic [31:0] v, input logic [31:0] lo,
                                     input logic [31:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/adc_prsnt_debounce.sv
// Board-present synchroniser and debouncer: present follows the synced pin
// only after DEBOUNCE_CYC consecutive disagreeing cycles.
module adc_prsnt_debounce #(
  parameter int DEBOUNCE_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic prsnt_b,
  output logic present
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      cnt     <= '0;
      present <= 1'b0;
    end else begin
      sync1 <= ~prsnt_b;
      sync2 <= sync1;
      if (sync2 == present) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        present <= sync2;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_board_seq.sv
// Sequencer for hot-pluggable ADC boards: debounce presence, power, trigger
// config, check test-pattern levels, and raise run once any board is good.
module adc_board_seq
  import adc_seq_pkg::*;
#(
  parameter int N_BOARDS     = 2,
  parameter int CH_PER_BOARD = 8,
  parameter int W            = 12,
  parameter int DEBOUNCE_CYC = 1000,
  parameter int SETTLE_CYC   = 1000,
  parameter int CFG_TIMEOUT  = 4095,
  parameter int CHECK_CYC    = 256,
  parameter int CHK_TIMEOUT  = 4095,
  parameter logic [W-1:0] LEVEL_LO = W'(LEVEL_LO_DEF),
  parameter logic [W-1:0] LEVEL_HI = W'(LEVEL_HI_DEF)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [N_BOARDS-1:0]                       prsnt_b,
  input  logic                                      cfg_done,
  input  logic [N_BOARDS*CH_PER_BOARD*W-1:0]        ch_in,
  input  logic [N_BOARDS*CH_PER_BOARD-1:0]          ch_pol,
  output logic [N_BOARDS*CH_PER_BOARD*W-1:0]        ch_out,
  output logic [N_BOARDS-1:0]                       pwr_en,
  output logic                                      cfg_start,
  output logic [((N_BOARDS > 1) ? $clog2(N_BOARDS) : 1)-1:0] cfg_sel,
  output logic [N_BOARDS-1:0]                       board_ok,
  output logic [N_BOARDS-1:0]                       board_err,
  output logic                                      run,
  output logic [2:0]                                dbg_state
);

  localparam int NCH   = N_BOARDS * CH_PER_BOARD;
  localparam int SEL_W = (N_BOARDS > 1) ? $clog2(N_BOARDS) : 1;
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int CFG_W = $clog2(CFG_TIMEOUT + 1);
  localparam int PAS_W = $clog2(CHECK_CYC + 1);
  localparam int CHK_W = $clog2(CHK_TIMEOUT + 1);

  logic [N_BOARDS-1:0] present;

  for (genvar b = 0; b < N_BOARDS; b++) begin : g_deb
    adc_prsnt_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
      .clk     (clk),
      .rst     (rst),
      .prsnt_b (prsnt_b[b]),
      .present (present[b])
    );
  end

  // Polarity correction: (2^W-1) - x is a bitwise invert.
  logic [NCH*W-1:0] ch_corr;
  always_comb begin
    ch_corr = ch_in;
    for (int c = 0; c < NCH; c++)
      if (ch_pol[c]) ch_corr[c*W +: W] = ~ch_in[c*W +: W];
  end

  // Per-board "every channel inside the window", using the registered samples.
  logic [N_BOARDS-1:0] board_win;
  always_comb begin
    board_win = '1;
    for (int b = 0; b < N_BOARDS; b++)
      for (int c = 0; c < CH_PER_BOARD; c++)
        if (!in_window(32'(ch_out[(b*CH_PER_BOARD+c)*W +: W]), 32'(LEVEL_LO), 32'(LEVEL_HI)))
          board_win[b] = 1'b0;
  end

  seq_state_t          state, state_d;
  logic [SEL_W-1:0]    sel_d, low_idx;
  logic [N_BOARDS-1:0] pwr_en_d, ok_d, err_d, eligible;
  logic                cfg_start_d, run_d;
  logic [SET_W-1:0]    settle_cnt, settle_d;
  logic [CFG_W-1:0]    cfg_cnt, cfg_cnt_d;
  logic [CHK_W-1:0]    chk_cnt, chk_d;
  logic [PAS_W-1:0]    pass_cnt, pass_d;

  assign eligible  = present & ~board_ok & ~board_err;
  assign dbg_state = state;

  always_comb begin
    low_idx = '0;
    for (int i = N_BOARDS - 1; i >= 0; i--)
      if (eligible[i]) low_idx = SEL_W'(i);
  end

  always_comb begin
    state_d     = state;
    sel_d       = cfg_sel;
    // Removed boards lose power and status on the following cycle.
    pwr_en_d    = pwr_en & present;
    ok_d        = board_ok & present;
    err_d       = board_err & present;
    cfg_start_d = 1'b0;
    settle_d    = settle_cnt;
    cfg_cnt_d   = cfg_cnt;
    chk_d       = chk_cnt;
    pass_d      = pass_cnt;
    run_d       = (state == ST_RUN) && (|board_ok);

    unique case (state)
      ST_SCAN: begin
        if (|eligible) begin
          sel_d             = low_idx;
          pwr_en_d[low_idx] = 1'b1;
          settle_d          = '0;
          state_d           = ST_PWR;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PWR: begin
        if (!present[cfg_sel]) begin
          state_d = ST_SCAN;
        end else if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
          cfg_start_d = 1'b1;
          cfg_cnt_d   = '0;
          state_d     = ST_CFG;
        end else begin
          settle_d = settle_cnt + 1'b1;
        end
      end
      ST_CFG: begin
        if (!present[cfg_sel]) begin
          state_d = ST_SCAN;
        end else if (cfg_done) begin
          chk_d   = '0;
          pass_d  = '0;
          state_d = ST_CHK;
        end else if (cfg_cnt == CFG_W'(CFG_TIMEOUT - 1)) begin
          err_d[cfg_sel]    = 1'b1;
          pwr_en_d[cfg_sel] = 1'b0;
          state_d           = ST_SCAN;
        end else begin
          cfg_cnt_d = cfg_cnt + 1'b1;
        end
      end
      ST_CHK: begin
        if (!present[cfg_sel]) begin
          state_d = ST_SCAN;
        end else if (board_win[cfg_sel] && (pass_cnt == PAS_W'(CHECK_CYC - 1))) begin
          ok_d[cfg_sel] = 1'b1;
          state_d       = ST_SCAN;
        end else if (chk_cnt == CHK_W'(CHK_TIMEOUT - 1)) begin
          err_d[cfg_sel]    = 1'b1;
          pwr_en_d[cfg_sel] = 1'b0;
          state_d           = ST_SCAN;
        end else begin
          chk_d  = chk_cnt + 1'b1;
          pass_d = board_win[cfg_sel] ? pass_cnt + 1'b1 : '0;
        end
      end
      ST_RUN: begin
        if (|eligible) state_d = ST_SCAN;
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_SCAN;
      cfg_sel    <= '0;
      pwr_en     <= '0;
      board_ok   <= '0;
      board_err  <= '0;
      cfg_start  <= 1'b0;
      run        <= 1'b0;
      settle_cnt <= '0;
      cfg_cnt    <= '0;
      chk_cnt    <= '0;
      pass_cnt   <= '0;
      ch_out     <= '0;
    end else begin
      state      <= state_d;
      cfg_sel    <= sel_d;
      pwr_en     <= pwr_en_d;
      board_ok   <= ok_d;
      board_err  <= err_d;
      cfg_start  <= cfg_start_d;
      run        <= run_d;
      settle_cnt <= settle_d;
      cfg_cnt    <= cfg_cnt_d;
      chk_cnt    <= chk_d;
      pass_cnt   <= pass_d;
      ch_out     <= ch_corr;
    end
  end

endmodule
